// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC register and steers the external 2:1
// PC select mux through sequential fetch, stalls, branch redirects and halt.
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = {PC_WIDTH{1'b0}},
  parameter int                  INSTR_BYTES  = 4,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt_req,
  input  logic [PC_WIDTH-1:0] pc_next,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_seq,
  output logic [PC_WIDTH-1:0] pc_redirect,
  output logic                pc_sel,
  output logic                fetch_valid,
  output logic                flush,
  output logic                misalign_err,
  output logic                halted
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [2:0]          FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [PC_WIDTH-1:0] INCR       = PC_WIDTH'(INSTR_BYTES);

  state_t              state_r, state_nxt_s;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pend_r, pend_nxt_s;
  logic [2:0]          flush_cnt_r, flush_cnt_nxt_s;
  logic                pc_en_s;
  logic                pc_sel_s;
  logic                misalign_s;
  logic                fetch_valid_r;
  logic                flush_r;
  logic                misalign_r;
  logic                halted_r;

  function automatic logic is_misaligned(input logic [PC_WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  function automatic logic [PC_WIDTH-1:0] align_addr(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

  // Next-state, mux select and PC enable decode.
  always_comb begin
    state_nxt_s     = state_r;
    pend_nxt_s      = pend_r;
    flush_cnt_nxt_s = flush_cnt_r;
    pc_en_s         = 1'b0;
    pc_sel_s        = 1'b0;
    misalign_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (branch_taken) begin
          misalign_s = is_misaligned(branch_target);
          if (!stall) begin
            pc_sel_s        = 1'b1;
            pc_en_s         = 1'b1;
            state_nxt_s     = ST_FLUSH;
            flush_cnt_nxt_s = FLUSH_INIT;
          end else begin
            pend_nxt_s  = align_addr(branch_target);
            state_nxt_s = ST_PEND;
          end
        end else if (halt_req) begin
          // A stalled halt is dropped; decode presents it again after the stall.
          if (!stall) begin
            state_nxt_s = ST_HALTED;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else if (stall) begin
          pc_en_s = 1'b0;
        end else begin
          pc_en_s = 1'b1;
        end
      end
      ST_PEND: begin
        if (!stall) begin
          pc_sel_s        = 1'b1;
          pc_en_s         = 1'b1;
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = FLUSH_INIT;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      ST_FLUSH: begin
        pc_en_s = 1'b1;
        if (flush_cnt_r <= 3'd1) begin
          flush_cnt_nxt_s = 3'd0;
          state_nxt_s     = ST_RUN;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r - 3'd1;
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State, PC and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      pend_r        <= {PC_WIDTH{1'b0}};
      flush_cnt_r   <= 3'd0;
      fetch_valid_r <= 1'b0;
      flush_r       <= 1'b0;
      misalign_r    <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pend_r        <= pend_nxt_s;
      flush_cnt_r   <= flush_cnt_nxt_s;
      if (pc_en_s) begin
        pc_r <= pc_next;
      end else begin
        pc_r <= pc_r;
      end
      fetch_valid_r <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_FLUSH);
      flush_r       <= (state_nxt_s == ST_FLUSH);
      misalign_r    <= misalign_s;
      halted_r      <= (state_nxt_s == ST_HALTED);
    end
  end

  assign pc           = pc_r;
  assign pc_seq       = pc_r + INCR;
  assign pc_redirect  = (state_r == ST_PEND) ? pend_r : align_addr(branch_target);
  assign pc_sel       = pc_sel_s;
  assign fetch_valid  = fetch_valid_r;
  assign flush        = flush_r;
  assign misalign_err = misalign_r;
  assign halted       = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the external PC select mux is modelled here.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        halt_req = 1'b0;
  logic [63:0] pc_next;
  logic [63:0] pc, pc_seq, pc_redirect;
  logic        pc_sel, fetch_valid, flush, misalign_err, halted;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req), .pc_next(pc_next),
    .pc(pc), .pc_seq(pc_seq), .pc_redirect(pc_redirect), .pc_sel(pc_sel),
    .fetch_valid(fetch_valid), .flush(flush), .misalign_err(misalign_err),
    .halted(halted)
  );

  assign pc_next = pc_sel ? pc_redirect : pc_seq;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [63:0] e_pc, input logic e_fv,
                          input logic e_fl, input logic e_mis, input logic e_halt);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".fetch_valid"}, {63'h0, fetch_valid}, {63'h0, e_fv});
    chk({tag, ".flush"}, {63'h0, flush}, {63'h0, e_fl});
    chk({tag, ".misalign"}, {63'h0, misalign_err}, {63'h0, e_mis});
    chk({tag, ".halted"}, {63'h0, halted}, {63'h0, e_halt});
  endtask

  initial begin
    // Reset and sequential fetch
    step(); step();
    chk_regs("rst", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.pc_sel", {63'h0, pc_sel}, 64'h0);
    reset = 1'b0; #1;
    chk("idle0.pc_sel", {63'h0, pc_sel}, 64'h0);
    chk("idle0.fv", {63'h0, fetch_valid}, 64'h0);
    step(); chk_regs("idle1", 64'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle1.pc_sel", {63'h0, pc_sel}, 64'h0);
    step(); chk_regs("idle2", 64'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_regs("idle3", 64'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk("idle4.pc", pc, 64'h10);

    // Immediate redirect, branch during flush ignored
    branch_taken = 1'b1; branch_target = 64'h100; #1;
    chk("br.pc_sel", {63'h0, pc_sel}, 64'h1);
    chk("br.redirect", pc_redirect, 64'h100);
    step(); chk_regs("br1", 64'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    branch_target = 64'h500; #1;
    chk("brfl.pc_sel", {63'h0, pc_sel}, 64'h0);
    step(); chk_regs("br2", 64'h104, 1'b1, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b0;
    step(); chk_regs("br3", 64'h108, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk("br4.pc", pc, 64'h10C);

    // Deferred redirect behind a 3-cycle stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h200; #1;
    chk("pd0.pc_sel", {63'h0, pc_sel}, 64'h0);
    step(); chk_regs("pd1", 64'h10C, 1'b0, 1'b0, 1'b0, 1'b0);
    branch_target = 64'h300; #1;
    chk("pd1.redirect", pc_redirect, 64'h200);
    chk("pd1.pc_sel", {63'h0, pc_sel}, 64'h0);
    step(); chk_regs("pd2", 64'h10C, 1'b0, 1'b0, 1'b0, 1'b0);
    branch_taken = 1'b0;
    step(); chk_regs("pd3", 64'h10C, 1'b0, 1'b0, 1'b0, 1'b0);
    stall = 1'b0; #1;
    chk("pd3.pc_sel", {63'h0, pc_sel}, 64'h1);
    chk("pd3.redirect", pc_redirect, 64'h200);
    step(); chk_regs("pd4", 64'h200, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk_regs("pd5", 64'h204, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk_regs("pd6", 64'h208, 1'b1, 1'b0, 1'b0, 1'b0);

    // Misaligned target
    branch_taken = 1'b1; branch_target = 64'h103; #1;
    chk("mis.redirect", pc_redirect, 64'h100);
    step(); chk_regs("mis1", 64'h100, 1'b1, 1'b1, 1'b1, 1'b0);
    branch_taken = 1'b0;
    step(); chk_regs("mis2", 64'h104, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk_regs("mis3", 64'h108, 1'b1, 1'b0, 1'b0, 1'b0);

    // Wrap at top of address space
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFF4;
    step(); chk("wr1.pc", pc, 64'hFFFF_FFFF_FFFF_FFF4);
    branch_taken = 1'b0;
    step(); step(); chk_regs("wr3", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wr3.pc_seq", pc_seq, 64'h0);
    step(); chk_regs("wr4", 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); step(); chk("wr6.pc", pc, 64'h8);

    // Halt: ignored under stall, then terminal until reset
    halt_req = 1'b1; stall = 1'b1;
    step(); chk_regs("hs", 64'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk_regs("h1", 64'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    halt_req = 1'b0; branch_taken = 1'b1; branch_target = 64'h700;
    for (int i = 0; i < 10; i++) step();
    chk_regs("h11", 64'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("h11.pc_sel", {63'h0, pc_sel}, 64'h0);
    branch_taken = 1'b0; reset = 1'b1;
    step(); chk_regs("hrst", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-FLUSH
    reset = 1'b0;
    step(); chk("rf0.pc", pc, 64'h4);
    branch_taken = 1'b1; branch_target = 64'h400;
    step(); chk_regs("rf1", 64'h400, 1'b1, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b0; reset = 1'b1;
    step(); chk_regs("rf2", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(); chk_regs("rf3", 64'h4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-PEND
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h600;
    step(); chk_regs("rp1", 64'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    branch_taken = 1'b0; reset = 1'b1;
    step(); chk_regs("rp2", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; stall = 1'b0; #1;
    chk("rp2.pc_sel", {63'h0, pc_sel}, 64'h0);
    step(); chk_regs("rp3", 64'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_regs("rp4", 64'h8, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
